// File: rtl/buffer_ctrl.sv
// buffer_ctrl: loads a block of 1..DEPTH 32-bit words from two requesters into an
// attached buffer, round-robin arbitrated, then issues a one-cycle read strobe and a
// one-cycle done pulse.
//
// Ports:
//   clk, reset (async, active-low)
//   start, len, flush               - command interface
//   req{0,1}_valid/data/ready       - requester handshakes (ready is combinational)
//   buf_address/data/en_write/en_read - buffer write port and read strobe
//   busy, done, err, count          - status
module buffer_ctrl #(
    parameter int unsigned DEPTH  = 128,
    parameter int unsigned ADDR_W = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        len,
    input  logic              flush,
    input  logic              req0_valid,
    input  logic [31:0]       req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [31:0]       req1_data,
    output logic              req1_ready,
    output logic [ADDR_W-1:0] buf_address,
    output logic [31:0]       buf_data,
    output logic              buf_en_write,
    output logic              buf_en_read,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [7:0]        count
);

    typedef enum logic [1:0] {StIdle, StLoad, StRead, StDone} state_e;

    localparam logic [8:0] MaxLen = 9'(DEPTH);

    state_e            state_q, state_d;
    logic [7:0]        len_q, len_d;
    logic [7:0]        count_q, count_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    // 0: req0 wins a tie next, 1: req1 wins a tie next
    logic              rr_q, rr_d;
    logic              err_q, err_d;

    logic grant0, grant1, accept, len_ok, can_accept;

    always_comb begin
        len_ok     = (len != 8'd0) && ({1'b0, len} <= MaxLen);
        can_accept = (state_q == StLoad) && (count_q < len_q) && !flush;

        grant0 = 1'b0;
        grant1 = 1'b0;
        if (can_accept) begin
            if (req0_valid && req1_valid) begin
                grant0 = !rr_q;
                grant1 = rr_q;
            end else begin
                grant0 = req0_valid;
                grant1 = req1_valid;
            end
        end
        accept = grant0 || grant1;

        req0_ready   = grant0;
        req1_ready   = grant1;
        buf_en_write = accept;
        buf_address  = accept ? wr_ptr_q : '0;
        buf_data     = grant0 ? req0_data : (grant1 ? req1_data : 32'd0);
        buf_en_read  = (state_q == StRead) && !flush;
        busy         = (state_q != StIdle);
        done         = (state_q == StDone);
        err          = err_q;
        count        = count_q;
    end

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rr_d     = rr_q;
        err_d    = 1'b0;

        if (flush) begin
            // Flush beats everything, including a coincident start.
            state_d  = StIdle;
            count_d  = 8'd0;
            wr_ptr_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        if (len_ok) begin
                            len_d    = len;
                            count_d  = 8'd0;
                            wr_ptr_d = '0;
                            state_d  = StLoad;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                StLoad: begin
                    if (accept) begin
                        wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                        count_d  = count_q + 8'd1;
                        rr_d     = grant0;
                        if (count_q + 8'd1 == len_q) begin
                            state_d = StRead;
                        end
                    end
                end
                StRead:  state_d = StDone;
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            len_q    <= 8'd0;
            count_q  <= 8'd0;
            wr_ptr_q <= '0;
            rr_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rr_q     <= rr_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: doc/buffer_ctrl.md
BUFFER_CTRL -- requirements
Module: buffer_ctrl

Interface
REQ-001 The block SHALL use parameter DEPTH, default 128, as the number of 32-bit entries in the attached buffer.
REQ-002 The block SHALL use parameter ADDR_W, default 7, as the buffer address width, with log2(DEPTH) = ADDR_W.
REQ-003 The block SHALL have the following ports, clock and reset first:
- clk  in  1  sole clock; all state changes on posedge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle load request
- len  in  8  number of words to load, legal range 1..DEPTH
- flush  in  1  abort the current operation
- req0_valid  in  1  requester 0 has a word
- req0_data  in  32  requester 0 word
- req0_ready  out  1  requester 0 word accepted this cycle
- req1_valid  in  1  requester 1 has a word
- req1_data  in  32  requester 1 word
- req1_ready  out  1  requester 1 word accepted this cycle
- buf_address  out  ADDR_W  buffer write address
- buf_data  out  32  buffer write data
- buf_en_write  out  1  buffer write strobe
- buf_en_read  out  1  buffer read strobe
- busy  out  1  state is not IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle illegal-len pulse
- count  out  8  words written in the current load
REQ-004 Reset SHALL be asynchronous and active-low on port reset, and the single clock SHALL be clk.

Function
REQ-005 The FSM SHALL have exactly four states: IDLE, LOAD, READ and DONE.
REQ-006 In IDLE, a start with 1 <= len <= DEPTH SHALL latch len, clear wr_ptr and count, and move to LOAD on the next edge.
REQ-007 In IDLE, a start with len = 0 or len > DEPTH SHALL pulse err for one cycle and leave the state at IDLE.
REQ-008 A start received outside IDLE SHALL be ignored, with no err pulse.
REQ-009 In LOAD, at most one requester SHALL be granted per cycle, and only a requester whose valid is high.
REQ-010 When both requesters are valid, the grant SHALL be round-robin: the requester not granted most recently wins.
REQ-011 After reset, the round-robin pointer SHALL favour req0.
REQ-012 reqN_ready SHALL be combinational and high only in LOAD, for the granted requester, when count < len and flush is low.
REQ-013 An accept (reqN_valid and reqN_ready both high) SHALL drive buf_en_write = 1, buf_address = wr_ptr and buf_data = the granted data in the same cycle, so the buffer writes at that edge with zero added latency.
REQ-014 Each accept SHALL increment wr_ptr and count by 1 on that edge.
REQ-015 wr_ptr SHALL never exceed DEPTH-1, because len caps the number of writes; no address wrap SHALL occur within a load.
REQ-016 When neither requester is valid in LOAD, the block SHALL write nothing and hold state, with no timeout.
REQ-017 When count reaches len, the FSM SHALL move to READ on the same edge as the final accept.
REQ-018 READ SHALL last exactly one cycle with buf_en_read = 1, then move to DONE; the buffer outputs therefore update at the end of the READ cycle.
REQ-019 DONE SHALL last exactly one cycle with done = 1, then move to IDLE; count SHALL hold its final value until the next start or flush.
REQ-020 When neither an accept (REQ-013) nor READ (REQ-018) applies, buf_address, buf_data, buf_en_write and buf_en_read SHALL all be 0.
REQ-021 busy SHALL be 1 in LOAD, READ and DONE, and 0 in IDLE.
REQ-022 flush SHALL take priority over all other activity in every state: no accept and no buf_en_read that cycle, next state IDLE, count and wr_ptr cleared.
REQ-023 Simultaneous start and flush in IDLE SHALL act as flush, with no load and no err.

Reset
REQ-024 While reset is low, the state SHALL be IDLE and busy, done, err, buf_en_write, buf_en_read, req0_ready and req1_ready SHALL all be 0.
REQ-025 While reset is low, count, wr_ptr, buf_address, buf_data and the latched len SHALL be 0, and the round-robin pointer SHALL favour req0.
REQ-026 A reset asserted mid-LOAD SHALL abandon the load immediately with no further buffer writes; buffer contents already written are not this block's concern.

Verification
REQ-027 Basic load: start with len=4; req0 supplies A0..A3 continuously -> buf_address 0,1,2,3 on four consecutive cycles with data A0..A3, then buf_en_read for one cycle, then done for one cycle, final count = 4.
REQ-028 Fair arbitration: len=6; req0 and req1 both valid throughout -> grant order req0, req1, req0, req1, req0, req1 at addresses 0..5.
REQ-029 Illegal length: start with len=0, then start with len=129 -> err pulses once for each; busy stays 0; no buf_en_write.
REQ-030 Full depth: len=128 with req1 only and valid gaps every third cycle -> 128 writes to addresses 0..127 with no write during a gap, then buf_en_read, done, count = 128.
REQ-031 Flush mid-load: len=10; flush asserted on the 5th accept cycle -> that word is not written, state returns to IDLE, count = 0, no buf_en_read and no done.
REQ-032 Async reset: reset driven low between clock edges during LOAD -> busy and all strobes go to 0 immediately; after release, start with len=2 writes addresses 0 and 1.
